// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t : controller states (IDLE, CALC, DONE)
//   clog2() : bit width needed to hold a step count of 0 .. value-1 (minimum 1)
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_sub_borrow_stage.sv
// Ripple-borrow subtractor: diff = a - b, borrow_out set when a < b.
// Ports:
//   a, b       : N-bit unsigned operands
//   diff       : N-bit difference (modulo 2^N)
//   borrow_out : borrow out of the most significant bit
module sub_borrow_stage #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] borrow;

  always_comb begin
    borrow = '0;
    diff   = '0;
    for (int i = 0; i < N; i++) begin
      diff[i]       = a[i] ^ b[i] ^ borrow[i];
      borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end
    borrow_out = borrow[N];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one subtract-and-shift step per clock.
// Optional feature macro: DIVIDER_DBZ_EN (adds div_by_zero port and a
// one-cycle bypass for a zero divisor).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   dividend, divisor    : unsigned operands, sampled on accept
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   quotient, remainder  : registered results, stable while out_valid
//   busy                 : high in CALC and DONE
//   div_by_zero          : (DIVIDER_DBZ_EN only) result came from a zero divisor
//
// state | meaning
// IDLE  | waiting for an operand pair
// CALC  | one restoring step per cycle, cnt counts down to 0
// DONE  | result presented until out_ready
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
`ifdef DIVIDER_DBZ_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             accept;
  logic             zero_bypass;

  // The partial remainder stays below the divisor, so its top bit never
  // reaches the outputs; it is kept only so R matches the subtractor width.
  logic unused_r_msb;
  assign unused_r_msb = r_reg[WIDTH];

  assign accept = in_valid && (state == IDLE);

`ifdef DIVIDER_DBZ_EN
  assign zero_bypass = (divisor == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  // Next partial remainder candidate: shift in the next dividend bit.
  assign s = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  sub_borrow_stage #(
    .N(WIDTH + 1)
  ) u_sub (
    .a         (s),
    .b         ({1'b0, d_reg}),
    .diff      (diff),
    .borrow_out(borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = zero_bypass ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      d_reg <= divisor;
      cnt   <= CNT_LOAD;
      if (zero_bypass) begin
        q_reg <= '1;
        r_reg <= {1'b0, dividend};
      end else begin
        q_reg <= dividend;
        r_reg <= '0;
      end
    end else if (state == CALC) begin
      r_reg <= borrow ? s : diff;
      q_reg <= {q_reg[WIDTH-2:0], ~borrow};
      cnt   <= cnt - 1'b1;
    end
  end

`ifdef DIVIDER_DBZ_EN
  logic dbz_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)      dbz_reg <= 1'b0;
    else if (accept) dbz_reg <= zero_bypass;
  end

  assign div_by_zero = dbz_reg;
`endif

  assign quotient  = q_reg;
  assign remainder = r_reg[WIDTH-1:0];

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
`ifdef DIVIDER_DBZ_EN
  logic             div_by_zero;
`endif

  int total = 0;
  int bad   = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy)
`ifdef DIVIDER_DBZ_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all ones / dividend.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MASK : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input int b);
`ifdef DIVIDER_DBZ_EN
    return (b == 0) ? 1 : WIDTH;
`else
    if (b == 0) return WIDTH;
    return WIDTH;
`endif
  endfunction

  // One full transaction: accept, wait for result, optionally stall, release.
  task automatic do_div(input int a, input int b, input int hold, input bit pulse);
    int  lat;
    bit  done;
    int  eq, er;
    eq = ref_q(a, b);
    er = ref_r(a, b);
    @(negedge clk);
    chk("in_ready_pre", int'(in_ready), 1);
    in_valid = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat++;
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else if (pulse && lat == 1) begin
        chk("in_ready_calc", int'(in_ready), 0);
        in_valid = 1'b1;
        dividend = WIDTH'(a ^ 5);
        divisor  = WIDTH'(b ^ 3);
      end
    end
    chk($sformatf("lat %0d/%0d", a, b), lat, ref_lat(b));
    chk($sformatf("q %0d/%0d", a, b), int'(quotient), eq);
    chk($sformatf("r %0d/%0d", a, b), int'(remainder), er);
`ifdef DIVIDER_DBZ_EN
    chk($sformatf("dbz %0d/%0d", a, b), int'(div_by_zero), (b == 0) ? 1 : 0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_q", int'(quotient), eq);
      chk("hold_r", int'(remainder), er);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_in_ready", int'(in_ready), 1);
    chk("rel_out_valid", int'(out_valid), 0);
    chk("rel_busy", int'(busy), 0);
  endtask

  initial begin
    int a, b, seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    rst_n = 1'b1;

    do_div(13, 3, 0, 1'b0);
    do_div(15, 1, 0, 1'b0);
    do_div(5, 7, 0, 1'b0);
    do_div(0, 9, 0, 1'b0);
    do_div(9, 0, 0, 1'b0);
    do_div(14, 4, 3, 1'b0);
    do_div(11, 2, 0, 1'b1);

    // Reset during the second CALC cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 4'd7;
    divisor  = 4'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    do_div(12, 5, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      a = int'($urandom_range(0, MASK));
      b = int'($urandom_range(0, MASK));
      if (n % 7 == 0) b = 0;
      do_div(a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
